scene_sequencer: RTL and testbench
==================================

SCENE_SEQUENCER -- requirements
Module: scene_sequencer

Interface
REQ-001 Parameter FRAMES_PER_SCENE, default 120, frames per scene (legal 1..255).
REQ-002 Parameter COLOR_STEP, default 8, frames per solid_color increment in SOLID scene (legal 1..255).
REQ-003 clk  input  1  pixel clock, all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 vsync  input  1  vertical sync from the hvsync generator, active-high, synchronous to clk.
REQ-006 pause  input  1  high: freeze all counters and state; outputs hold.
REQ-007 skip  input  1  single-cycle pulse: request advance to next scene at next frame tick.
REQ-008 background_state  output  8  pattern select for pixel_color: [7:6] scene code, [5:0] phase.
REQ-009 solid_color  output  6  RRGGBB colour for pixel_color.
REQ-010 audio_en  output  1  audio generator enable.

Function
REQ-011 Frame tick SHALL be the rising edge of vsync: tick = vsync & ~vsync_q, vsync_q a register of vsync.
REQ-012 All outputs SHALL be registered and update on the clk edge that samples the tick (one cycle after vsync first seen high by vsync_q logic); no other cycle changes them.
REQ-013 FSM states SHALL be SOLID(2'd0) -> BARS(2'd1) -> CHECKER(2'd2) -> SCROLL(2'd3) -> SOLID; background_state[7:6] = current state code.
REQ-014 An 8-bit frame_cnt SHALL increment on each tick; on a tick with frame_cnt == FRAMES_PER_SCENE-1, frame_cnt -> 0 and FSM advances one state.
REQ-015 background_state[5:0] SHALL be a 6-bit phase counter incrementing on each tick, wrapping 63 -> 0, cleared to 0 on every scene change.
REQ-016 In SOLID, an 8-bit step counter SHALL count ticks; on the tick where it equals COLOR_STEP-1 it clears and solid_color increments mod 64 (63 -> 0).
REQ-017 Outside SOLID, solid_color and step counter SHALL hold; on entry to SOLID the step counter SHALL be 0 and solid_color continues from its held value.
REQ-018 audio_en SHALL be 0 in SOLID and 1 in BARS, CHECKER, SCROLL; updates with the state register.
REQ-019 skip SHALL set a sticky skip_pending flag; at the next tick with skip_pending set, FSM advances, frame_cnt and phase clear to 0, skip_pending clears.
REQ-020 skip and tick in the same cycle SHALL advance on that tick; skip coinciding with a natural scene-end tick SHALL advance exactly one state, not two.
REQ-021 Additional skip pulses while skip_pending is set SHALL be absorbed (one advance total).
REQ-022 While pause=1, ticks SHALL be ignored for counters, FSM and colour; vsync_q still tracks vsync; skip_pending still captures skip and is acted on at the first tick after pause falls.
REQ-023 No other inputs SHALL influence state; no combinational path from any input to any output.

Reset
REQ-024 On rst_n low, asynchronously: state=SOLID, frame_cnt=0, phase=0, step=0, skip_pending=0, solid_color=6'h3F, audio_en=0, background_state=8'h00.
REQ-025 vsync_q SHALL reset to 1 so vsync already high at reset release produces no tick.
REQ-026 Reset asserted mid-scene SHALL discard all progress; first tick after release behaves as frame 1 of SOLID.

Verification
REQ-027 Reset, then 8 vsync pulses (COLOR_STEP=8) -> solid_color 3F -> 00 after 8th tick, phase=8, audio_en=0.
REQ-028 FRAMES_PER_SCENE=4: 16 vsync pulses -> background_state[7:6] sequence 0,1,2,3,0 changing on ticks 4,8,12,16; audio_en 0,1,1,1,0.
REQ-029 skip pulse mid-SOLID at frame 2, then one tick -> state BARS, phase 0; second skip same cycle as tick -> CHECKER, single advance.
REQ-030 FRAMES_PER_SCENE=4, skip asserted in the cycle of the 4th tick -> state advances to BARS only, not CHECKER.
REQ-031 pause=1 over 10 vsync pulses with a skip -> outputs unchanged; pause=0, next tick -> advance by skip.
REQ-032 rst_n pulsed low asynchronously (between clk edges) in SCROLL with vsync held high across release -> outputs at reset values immediately, no tick on release.

Source files
------------

// File: rtl/scene_sequencer.sv
// scene_sequencer: frame-driven scene FSM producing background pattern select, solid colour and audio enable
module scene_sequencer #(
  parameter int FRAMES_PER_SCENE = 120,
  parameter int COLOR_STEP       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       skip,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic       audio_en
);
  typedef enum logic [1:0] {SOLID = 2'd0, BARS = 2'd1, CHECKER = 2'd2, SCROLL = 2'd3} state_t;
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SCENE - 1);
  localparam logic [7:0] STEP_LAST  = 8'(COLOR_STEP - 1);
  state_t     state, state_nxt;
  logic       vsync_q, skip_pending, skip_pending_nxt, act, adv, solid_tick, step_wrap;
  logic [7:0] frame_cnt, frame_nxt, step, step_nxt;
  logic [5:0] phase, phase_nxt, color_nxt;
  assign act              = vsync & ~vsync_q & ~pause;
  assign adv              = act & (skip_pending | skip | frame_cnt == FRAME_LAST);
  assign solid_tick       = act & state == SOLID;
  assign step_wrap        = step == STEP_LAST;
  assign background_state = {state, phase};
  // vsync_q resets high so a vsync already high at reset release is not a tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b1;
      state        <= SOLID;
      frame_cnt    <= '0;
      phase        <= '0;
      step         <= '0;
      skip_pending <= 1'b0;
      solid_color  <= 6'h3F;
      audio_en     <= 1'b0;
    end else begin
      vsync_q      <= vsync;
      state        <= state_nxt;
      frame_cnt    <= frame_nxt;
      phase        <= phase_nxt;
      step         <= step_nxt;
      skip_pending <= skip_pending_nxt;
      solid_color  <= color_nxt;
      audio_en     <= state_nxt != SOLID;
    end
  end
  // one scene step per advance, whether from scene end or skip (never two)
  always_comb begin
    state_nxt = adv ? state_t'(state + 2'd1) : state;
  end
  // counters and colour; step clears when wrapping back into SOLID
  always_comb begin
    skip_pending_nxt = act ? 1'b0 : (skip_pending | skip);
    frame_nxt        = act ? (adv ? 8'd0 : frame_cnt + 8'd1) : frame_cnt;
    phase_nxt        = act ? (adv ? 6'd0 : phase + 6'd1) : phase;
    step_nxt         = (adv & state == SCROLL) ? 8'd0 : solid_tick ? (step_wrap ? 8'd0 : step + 8'd1) : step;
    color_nxt        = (solid_tick & step_wrap) ? solid_color + 6'd1 : solid_color;
  end
endmodule

// File: tb/tb_scene_sequencer.sv
// tb_scene_sequencer: directed table-driven checks of scene_sequencer on two parameterisations
module tb_scene_sequencer;
  logic       clk = 1'b0, rst_n = 1'b0, vsync = 1'b0, pause = 1'b0, skip = 1'b0;
  logic [7:0] bs_a, bs_b;
  logic [5:0] sc_a, sc_b;
  logic       au_a, au_b;
  int         errors = 0, checks = 0;
  typedef struct {
    int         pre;
    bit         sk;
    logic [7:0] bs;
    logic [5:0] sc;
    logic       au;
  } vec_t;
  vec_t tbl[$];

  scene_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .skip(skip),
    .background_state(bs_a), .solid_color(sc_a), .audio_en(au_a)
  );
  scene_sequencer #(.FRAMES_PER_SCENE(4), .COLOR_STEP(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause), .skip(skip),
    .background_state(bs_b), .solid_color(sc_b), .audio_en(au_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic [7:0] bs, input logic [5:0] sc, input logic au);
    chk({name, " b.bg"}, bs_b, bs);
    chk({name, " b.color"}, {2'b00, sc_b}, {2'b00, sc});
    chk({name, " b.audio"}, {7'd0, au_b}, {7'd0, au});
  endtask

  task automatic chk_a(input string name, input logic [7:0] bs, input logic [5:0] sc, input logic au);
    chk({name, " a.bg"}, bs_a, bs);
    chk({name, " a.color"}, {2'b00, sc_a}, {2'b00, sc});
    chk({name, " a.audio"}, {7'd0, au_a}, {7'd0, au});
  endtask

  task automatic skip_pulse();
    @(negedge clk); skip = 1'b1;
    @(negedge clk); skip = 1'b0;
  endtask

  task automatic vs_pulse(input bit sk);
    @(negedge clk); vsync = 1'b1; skip = sk;
    @(negedge clk); skip = 1'b0;
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic add(input int pre, input bit sk, input logic [7:0] bs, input logic [5:0] sc, input logic au);
    vec_t v;
    v.pre = pre; v.sk = sk; v.bs = bs; v.sc = sc; v.au = au;
    tbl.push_back(v);
  endtask

  initial begin
    add(0, 0, 8'h01, 6'h3F, 0); add(0, 0, 8'h02, 6'h3F, 0); add(0, 0, 8'h03, 6'h00, 0);
    add(0, 0, 8'h40, 6'h00, 1); add(0, 0, 8'h41, 6'h00, 1); add(0, 0, 8'h42, 6'h00, 1);
    add(0, 0, 8'h43, 6'h00, 1); add(0, 0, 8'h80, 6'h00, 1); add(0, 0, 8'h81, 6'h00, 1);
    add(0, 0, 8'h82, 6'h00, 1); add(0, 0, 8'h83, 6'h00, 1); add(0, 0, 8'hC0, 6'h00, 1);
    add(0, 0, 8'hC1, 6'h00, 1); add(0, 0, 8'hC2, 6'h00, 1); add(0, 0, 8'hC3, 6'h00, 1);
    add(0, 0, 8'h00, 6'h00, 0); add(0, 0, 8'h01, 6'h00, 0); add(0, 0, 8'h02, 6'h00, 0);
    add(0, 0, 8'h03, 6'h01, 0);
    add(0, 1, 8'h40, 6'h01, 1); add(0, 0, 8'h41, 6'h01, 1);
    add(1, 0, 8'h80, 6'h01, 1); add(2, 0, 8'hC0, 6'h01, 1); add(0, 0, 8'hC1, 6'h01, 1);
    add(0, 1, 8'h00, 6'h01, 0);

    repeat (3) @(negedge clk);
    chk_a("reset", 8'h00, 6'h3F, 0);
    chk_b("reset", 8'h00, 6'h3F, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_b("post-release", 8'h00, 6'h3F, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int p = 0; p < tbl[i].pre; p++) skip_pulse();
      vs_pulse(tbl[i].sk);
      chk_b($sformatf("tick%0d", i + 1), tbl[i].bs, tbl[i].sc, tbl[i].au);
      if (i == 7) chk_a("tick8", 8'h08, 6'h00, 0);
      if (i == 15) chk_a("tick16", 8'h10, 6'h01, 0);
    end

    pause = 1'b1;
    skip_pulse();
    for (int i = 0; i < 10; i++) vs_pulse(0);
    chk_b("paused", 8'h00, 6'h01, 0);
    pause = 1'b0;
    repeat (2) @(negedge clk);
    chk_b("unpaused idle", 8'h00, 6'h01, 0);
    vs_pulse(0);
    chk_b("skip after pause", 8'h40, 6'h01, 1);
    vs_pulse(0);
    chk_b("single advance after pause", 8'h41, 6'h01, 1);

    skip_pulse(); vs_pulse(0);
    skip_pulse(); vs_pulse(0);
    chk_b("in scroll", 8'hC0, 6'h01, 1);

    @(negedge clk); vsync = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_b("async reset", 8'h00, 6'h3F, 0);
    chk_a("async reset", 8'h00, 6'h3F, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_b("no tick on release", 8'h00, 6'h3F, 0);
    @(negedge clk); vsync = 1'b0;
    @(negedge clk);
    vs_pulse(0);
    chk_b("first tick after reset", 8'h01, 6'h3F, 0);
    chk_a("first tick after reset", 8'h01, 6'h3F, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
